// File: rtl/pico_io_bridge.sv
// PicoBlaze port-mapped I/O bridge: board I/O registers, queued RAM probe
// sequencer, single-cycle RAM write path and masked edge-latched interrupts.
module pico_io_bridge #(
    parameter int          NUM_DIGITS  = 8,
    parameter int          LED_WIDTH   = 16,
    parameter int          PROBE_DEPTH = 5,
    parameter int          RAM_AW      = 8,
    parameter int          RAM_DW      = 2,
    parameter int          RAM_RD_LAT  = 1,
    parameter int          NUM_IRQ     = 4,
    parameter logic [7:0]  OOB_ADDR    = 8'hFF
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [7:0]              port_id,
    input  logic [7:0]              out_port,
    input  logic                    write_strobe,
    output logic [7:0]              in_port,
    output logic                    interrupt,
    input  logic                    interrupt_ack,
    input  logic [NUM_IRQ-1:0]      irq_src,
    input  logic [4:0]              db_btns,
    input  logic [15:0]             db_sw,
    output logic [LED_WIDTH-1:0]    leds,
    output logic [5*NUM_DIGITS-1:0] digits,
    output logic [NUM_DIGITS-1:0]   dp,
    output logic [RAM_AW-1:0]       ram_addr,
    output logic                    ram_we,
    output logic [RAM_DW-1:0]       ram_wdata,
    input  logic [RAM_DW-1:0]       ram_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Bits beyond the configured LED/digit count are forced to zero on write.
    localparam logic [15:0] LED_MASK = (LED_WIDTH == 16) ? 16'hFFFF : 16'h00FF;
    localparam logic [15:0] DP_MASK  = 16'((32'd1 << NUM_DIGITS) - 32'd1);

    state_t               state_r, state_nx_s;
    logic [7:0]           queue_r [16];
    logic [3:0]           cnt_r, idx_r;
    logic [1:0]           wait_r;
    logic [7:0]           hits_r;
    logic                 oob_r, ovf_r, done_r, valid_r, drop_r;
    logic [7:0]           waddr_r;
    logic [15:0]          led_r, dp_r;
    logic [4:0]           digit_r [16];
    logic [NUM_IRQ-1:0]   mask_r, pend_r, irq_prev_r;
    logic                 newly_r, interrupt_r;
    logic [7:0]           in_port_r, rd_data_s;
    logic [RAM_AW-1:0]    ram_addr_r;
    logic                 ram_we_r;
    logic [RAM_DW-1:0]    ram_wdata_r;

    logic                 busy_s, full_s, empty_s, ctrl_wr_s, clear_s, start_s;
    logic [7:0]           cur_entry_s;
    logic                 cur_oob_s, last_s, sample_s, dig_sel_s, evt_s;
    logic [NUM_IRQ-1:0]   rise_s, w1c_s;

    assign busy_s      = (state_r != ST_IDLE);
    assign full_s      = (cnt_r == 4'(PROBE_DEPTH));
    assign empty_s     = (cnt_r == 4'd0);
    assign ctrl_wr_s   = write_strobe && (port_id == 8'h08);
    assign clear_s     = ctrl_wr_s && out_port[1];
    assign start_s     = ctrl_wr_s && out_port[0] && !out_port[1];
    assign cur_entry_s = queue_r[idx_r];
    assign cur_oob_s   = (cur_entry_s == OOB_ADDR);
    assign last_s      = (({1'b0, idx_r} + 5'd1) >= {1'b0, cnt_r});
    assign sample_s    = (wait_r == 2'(RAM_RD_LAT));
    assign dig_sel_s   = (port_id[7:4] == 4'h2) && ({1'b0, port_id[3:0]} < 5'(NUM_DIGITS));
    assign rise_s      = irq_src & ~irq_prev_r;
    assign w1c_s       = (write_strobe && (port_id == 8'h0F)) ? out_port[NUM_IRQ-1:0]
                                                             : {NUM_IRQ{1'b0}};
    // Only a 0->1 transition of an enabled pending bit counts as a new event.
    assign evt_s       = |(rise_s & ~pend_r & mask_r);

    // Sequencer state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Sequencer next-state logic; clear aborts any probe in flight.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_s && !empty_s) begin
                    state_nx_s = ST_ISSUE;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (clear_s) begin
                    state_nx_s = ST_IDLE;
                end else if (cur_oob_s) begin
                    state_nx_s = last_s ? ST_DONE : ST_ISSUE;
                end else begin
                    state_nx_s = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (clear_s) begin
                    state_nx_s = ST_IDLE;
                end else if (sample_s) begin
                    state_nx_s = last_s ? ST_DONE : ST_ISSUE;
                end else begin
                    state_nx_s = ST_WAIT;
                end
            end
            ST_DONE: state_nx_s = ST_IDLE;
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // Probe queue, result flags, RAM address/write port.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 16; i++) begin
                queue_r[i] <= 8'h00;
            end
            cnt_r       <= 4'd0;
            idx_r       <= 4'd0;
            wait_r      <= 2'd0;
            hits_r      <= 8'h00;
            oob_r       <= 1'b0;
            ovf_r       <= 1'b0;
            done_r      <= 1'b0;
            valid_r     <= 1'b0;
            drop_r      <= 1'b0;
            ram_addr_r  <= {RAM_AW{1'b0}};
            ram_we_r    <= 1'b0;
            ram_wdata_r <= {RAM_DW{1'b0}};
        end else begin
            ram_we_r <= 1'b0;
            if (clear_s) begin
                cnt_r   <= 4'd0;
                idx_r   <= 4'd0;
                hits_r  <= 8'h00;
                oob_r   <= 1'b0;
                ovf_r   <= 1'b0;
                done_r  <= 1'b0;
                valid_r <= 1'b0;
                drop_r  <= 1'b0;
            end else begin
                if (write_strobe && (port_id == 8'h0C)) begin
                    if (busy_s) begin
                        drop_r <= 1'b1;
                    end else begin
                        ram_we_r    <= 1'b1;
                        ram_addr_r  <= waddr_r[RAM_AW-1:0];
                        ram_wdata_r <= out_port[RAM_DW-1:0];
                    end
                end
                if (write_strobe && (port_id == 8'h07) && !busy_s) begin
                    if (full_s) begin
                        ovf_r <= 1'b1;
                    end else begin
                        queue_r[cnt_r] <= out_port;
                        cnt_r          <= cnt_r + 4'd1;
                        if (out_port == OOB_ADDR) begin
                            oob_r <= 1'b1;
                        end
                    end
                end
                if (start_s && !busy_s) begin
                    idx_r <= 4'd0;
                    if (empty_s) begin
                        done_r  <= 1'b1;
                        valid_r <= 1'b1;
                    end else begin
                        hits_r  <= 8'h00;
                        done_r  <= 1'b0;
                        valid_r <= 1'b0;
                    end
                end
                case (state_r)
                    ST_ISSUE: begin
                        if (cur_oob_s) begin
                            oob_r <= 1'b1;
                            idx_r <= idx_r + 4'd1;
                        end else begin
                            ram_addr_r <= cur_entry_s[RAM_AW-1:0];
                            wait_r     <= 2'd0;
                        end
                    end
                    ST_WAIT: begin
                        wait_r <= wait_r + 2'd1;
                        if (sample_s) begin
                            if ((ram_rdata != {RAM_DW{1'b0}}) && (hits_r != 8'hFF)) begin
                                hits_r <= hits_r + 8'd1;
                            end
                            idx_r <= idx_r + 4'd1;
                        end
                    end
                    ST_DONE: begin
                        done_r  <= 1'b1;
                        valid_r <= (hits_r == 8'h00) && !oob_r;
                    end
                    default: begin
                        wait_r <= wait_r;
                    end
                endcase
            end
        end
    end

    // Port read mux; unmapped and out-of-range ports read zero.
    always_comb begin
        rd_data_s = 8'h00;
        case (port_id)
            8'h00: rd_data_s = {3'b000, db_btns};
            8'h01: rd_data_s = db_sw[7:0];
            8'h02: rd_data_s = db_sw[15:8];
            8'h03: rd_data_s = led_r[7:0];
            8'h04: rd_data_s = led_r[15:8];
            8'h05: rd_data_s = dp_r[7:0];
            8'h06: rd_data_s = dp_r[15:8];
            8'h08: rd_data_s = {busy_s, done_r, full_s, empty_s, cnt_r};
            8'h09: rd_data_s = {5'b00000, ovf_r, oob_r, valid_r};
            8'h0A: rd_data_s = hits_r;
            8'h0D: rd_data_s = {7'b0000000, drop_r};
            8'h0E: rd_data_s = 8'(mask_r);
            8'h0F: rd_data_s = 8'(pend_r);
            default: begin
                if (dig_sel_s) begin
                    rd_data_s = {3'b000, digit_r[port_id[3:0]]};
                end else begin
                    rd_data_s = 8'h00;
                end
            end
        endcase
    end

    // Board output registers, irq mask, write address and registered read data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            led_r     <= 16'h0000;
            dp_r      <= 16'h0000;
            mask_r    <= {NUM_IRQ{1'b0}};
            waddr_r   <= 8'h00;
            in_port_r <= 8'h00;
            for (int i = 0; i < 16; i++) begin
                digit_r[i] <= 5'd0;
            end
        end else begin
            in_port_r <= rd_data_s;
            if (write_strobe) begin
                case (port_id)
                    8'h03: led_r[7:0]  <= out_port & LED_MASK[7:0];
                    8'h04: led_r[15:8] <= out_port & LED_MASK[15:8];
                    8'h05: dp_r[7:0]   <= out_port & DP_MASK[7:0];
                    8'h06: dp_r[15:8]  <= out_port & DP_MASK[15:8];
                    8'h0B: waddr_r     <= out_port;
                    8'h0E: mask_r      <= out_port[NUM_IRQ-1:0];
                    default: begin
                        if (dig_sel_s) begin
                            digit_r[port_id[3:0]] <= out_port[4:0];
                        end
                    end
                endcase
            end
        end
    end

    // Edge-latched pending bits and interrupt line; a coincident new event beats ack.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_prev_r  <= {NUM_IRQ{1'b0}};
            pend_r      <= {NUM_IRQ{1'b0}};
            newly_r     <= 1'b0;
            interrupt_r <= 1'b0;
        end else begin
            irq_prev_r <= irq_src;
            pend_r     <= (pend_r & ~w1c_s) | rise_s;
            newly_r    <= evt_s;
            if (newly_r) begin
                interrupt_r <= 1'b1;
            end else if (interrupt_ack && !evt_s) begin
                interrupt_r <= 1'b0;
            end
        end
    end

    assign in_port   = in_port_r;
    assign interrupt = interrupt_r;
    assign leds      = led_r[LED_WIDTH-1:0];
    assign dp        = dp_r[NUM_DIGITS-1:0];
    assign ram_addr  = ram_addr_r;
    assign ram_we    = ram_we_r;
    assign ram_wdata = ram_wdata_r;

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digits
        assign digits[5*g +: 5] = digit_r[g];
    end

endmodule

// File: tb/tb_pico_io_bridge.sv
// Scoreboard bench for pico_io_bridge: stimulus queues expectations, a
// negedge monitor pops them as reads, RAM accesses and irq samples appear.
module tb_pico_io_bridge;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  port_id, out_port, in_port;
    logic        write_strobe, interrupt, interrupt_ack;
    logic [3:0]  irq_src;
    logic [4:0]  db_btns;
    logic [15:0] db_sw, leds;
    logic [39:0] digits;
    logic [7:0]  dp, ram_addr;
    logic        ram_we;
    logic [1:0]  ram_wdata, ram_rdata;

    pico_io_bridge dut (
        .clk(clk), .reset_n(reset_n), .port_id(port_id), .out_port(out_port),
        .write_strobe(write_strobe), .in_port(in_port), .interrupt(interrupt),
        .interrupt_ack(interrupt_ack), .irq_src(irq_src), .db_btns(db_btns),
        .db_sw(db_sw), .leds(leds), .digits(digits), .dp(dp), .ram_addr(ram_addr),
        .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    // One-cycle-latency RAM model
    logic [1:0] mem [256];
    always @(posedge clk) ram_rdata <= mem[ram_addr];

    typedef struct { logic [7:0] port; logic [7:0] exp; } rd_exp_t;
    typedef struct { logic [7:0] addr; logic [1:0] data; } wr_exp_t;
    rd_exp_t    rd_q[$];
    wr_exp_t    wr_q[$];
    logic [7:0] addr_q[$];
    logic       irq_q[$];
    rd_exp_t    re;
    wr_exp_t    we_e;
    logic [7:0] ea;
    logic       ei;

    int   errors = 0;
    int   checks = 0;
    logic rd_flag = 1'b0, rd_pend = 1'b0, irq_flag = 1'b0, mon_en = 1'b1;
    logic [7:0] last_addr = 8'h00;

    always @(posedge clk) rd_pend <= rd_flag;

    always @(negedge clk) begin
        if (rd_pend) begin
            checks++;
            if (rd_q.size() == 0) begin
                errors++;
                $display("FAIL read: unexpected read, got %02h", in_port);
            end else begin
                re = rd_q.pop_front();
                if (in_port !== re.exp) begin
                    errors++;
                    $display("FAIL read port %02h: got %02h expected %02h", re.port, in_port, re.exp);
                end
            end
        end
        if (irq_flag) begin
            checks++;
            ei = irq_q.pop_front();
            if (interrupt !== ei) begin
                errors++;
                $display("FAIL interrupt: got %b expected %b", interrupt, ei);
            end
        end
        if (ram_we === 1'b1) begin
            checks++;
            if (wr_q.size() == 0) begin
                errors++;
                $display("FAIL ram_we: unexpected pulse addr %02h data %0d", ram_addr, ram_wdata);
            end else begin
                we_e = wr_q.pop_front();
                if (ram_addr !== we_e.addr || ram_wdata !== we_e.data) begin
                    errors++;
                    $display("FAIL ram write: got %02h/%0d expected %02h/%0d",
                             ram_addr, ram_wdata, we_e.addr, we_e.data);
                end
            end
        end else if (mon_en && ram_addr !== last_addr) begin
            checks++;
            if (addr_q.size() == 0) begin
                errors++;
                $display("FAIL probe addr: unexpected %02h", ram_addr);
            end else begin
                ea = addr_q.pop_front();
                if (ram_addr !== ea) begin
                    errors++;
                    $display("FAIL probe addr: got %02h expected %02h", ram_addr, ea);
                end
            end
        end
        last_addr <= ram_addr;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] p, input logic [7:0] d);
        port_id = p; out_port = d; write_strobe = 1'b1;
        step();
        write_strobe = 1'b0; port_id = 8'h7F;
    endtask

    task automatic rd(input logic [7:0] p, input logic [7:0] e);
        rd_q.push_back('{p, e});
        port_id = p; rd_flag = 1'b1;
        step();
        rd_flag = 1'b0; port_id = 8'h7F;
    endtask

    task automatic exp_irq(input logic e);
        irq_q.push_back(e);
        irq_flag = 1'b1;
        step();
        irq_flag = 1'b0;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push_probe(input logic [7:0] a, input logic issued);
        wr(8'h07, a);
        if (issued) addr_q.push_back(a);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 2'b00;
        reset_n = 1'b0; port_id = 8'h7F; out_port = 8'h00; write_strobe = 1'b0;
        interrupt_ack = 1'b0; irq_src = 4'h0; db_btns = 5'h15; db_sw = 16'hBEEF;
        #2;
        chk("reset in_port", 64'(in_port), 64'h0);
        chk("reset ram_we", 64'(ram_we), 64'h0);
        chk("reset interrupt", 64'(interrupt), 64'h0);
        chk("reset leds", 64'(leds), 64'h0);
        chk("reset digits", 64'(digits), 64'h0);
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        step();
        rd(8'h08, 8'h10);
        rd(8'h09, 8'h00);

        // Three clean probes: exact latency through status reads
        push_probe(8'h11, 1'b1); push_probe(8'h12, 1'b1); push_probe(8'h13, 1'b1);
        wr(8'h08, 8'h01);
        repeat (9) step();
        rd(8'h08, 8'h83);
        rd(8'h08, 8'h43);
        rd(8'h09, 8'h01);
        rd(8'h0A, 8'h00);

        // One hit
        wr(8'h08, 8'h02);
        mem[8'h31] = 2'b01;
        push_probe(8'h30, 1'b1); push_probe(8'h31, 1'b1); push_probe(8'h32, 1'b1);
        wr(8'h08, 8'h01);
        repeat (12) step();
        rd(8'h09, 8'h00);
        rd(8'h0A, 8'h01);
        rd(8'h08, 8'h43);

        // Out-of-bounds entry is skipped
        wr(8'h08, 8'h02);
        push_probe(8'h20, 1'b1); push_probe(8'hFF, 1'b0);
        wr(8'h08, 8'h01);
        repeat (6) step();
        rd(8'h09, 8'h02);
        rd(8'h0A, 8'h00);
        rd(8'h08, 8'h42);

        // Start with an empty queue
        wr(8'h08, 8'h02);
        wr(8'h08, 8'h01);
        rd(8'h08, 8'h50);
        rd(8'h09, 8'h01);

        // Overflow then clear
        wr(8'h08, 8'h02);
        for (int i = 1; i <= 6; i++) push_probe(8'(i), 1'b0);
        rd(8'h08, 8'h25);
        rd(8'h09, 8'h04);
        wr(8'h08, 8'h02);
        rd(8'h08, 8'h10);
        rd(8'h09, 8'h00);

        // RAM write strobe, then a write dropped while busy
        rd(8'h0D, 8'h00);
        wr(8'h0B, 8'h42);
        wr_q.push_back('{8'h42, 2'b11});
        wr(8'h0C, 8'h03);
        step(); step();
        push_probe(8'h50, 1'b1);
        wr(8'h08, 8'h01);
        wr(8'h0C, 8'h03);
        rd(8'h0D, 8'h01);
        repeat (4) step();
        rd(8'h08, 8'h41);
        wr(8'h08, 8'h02);
        rd(8'h0D, 8'h00);

        // Interrupts
        wr(8'h0E, 8'h05);
        irq_src = 4'b0011;
        step();
        irq_src = 4'b0000;
        rd(8'h0F, 8'h03);
        exp_irq(1'b1);
        interrupt_ack = 1'b1;
        step();
        interrupt_ack = 1'b0;
        exp_irq(1'b0);
        wr(8'h0F, 8'h01);
        irq_src = 4'b0001;
        step();
        irq_src = 4'b0000;
        step();
        exp_irq(1'b1);
        interrupt_ack = 1'b1; irq_src = 4'b0100;
        step();
        interrupt_ack = 1'b0; irq_src = 4'b0000;
        exp_irq(1'b1);
        exp_irq(1'b1);
        rd(8'h0F, 8'h07);
        wr(8'h0F, 8'h07);
        rd(8'h0F, 8'h00);
        rd(8'h0E, 8'h05);

        // Board ports, including out-of-range ones
        rd(8'h00, 8'h15);
        rd(8'h01, 8'hEF);
        rd(8'h02, 8'hBE);
        wr(8'h03, 8'hA5); wr(8'h04, 8'h5A); wr(8'h05, 8'h81); wr(8'h06, 8'hFF);
        wr(8'h20, 8'h15); wr(8'h27, 8'h1F); wr(8'h28, 8'h1F);
        rd(8'h03, 8'hA5);
        rd(8'h04, 8'h5A);
        rd(8'h05, 8'h81);
        rd(8'h06, 8'h00);
        rd(8'h27, 8'h1F);
        rd(8'h28, 8'h00);
        rd(8'h40, 8'h00);
        chk("leds", 64'(leds), 64'h5AA5);
        chk("dp", 64'(dp), 64'h81);
        chk("digits", 64'(digits), 64'hF8_0000_0015);

        // Reset during WAIT
        mon_en = 1'b0;
        push_probe(8'h11, 1'b0); push_probe(8'h12, 1'b0);
        wr(8'h08, 8'h01);
        step();
        #1 reset_n = 1'b0;
        #1;
        chk("rst in_port", 64'(in_port), 64'h0);
        chk("rst leds", 64'(leds), 64'h0);
        chk("rst digits", 64'(digits), 64'h0);
        chk("rst dp", 64'(dp), 64'h0);
        chk("rst ram_addr", 64'(ram_addr), 64'h0);
        chk("rst ram_we", 64'(ram_we), 64'h0);
        chk("rst interrupt", 64'(interrupt), 64'h0);
        step();
        reset_n = 1'b1;
        rd(8'h08, 8'h10);
        rd(8'h09, 8'h00);
        rd(8'h0E, 8'h00);
        step(); step();

        chk("read queue drained", 64'(rd_q.size()), 64'h0);
        chk("write queue drained", 64'(wr_q.size()), 64'h0);
        chk("probe addr queue drained", 64'(addr_q.size()), 64'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pico_io_bridge.md
# pico_io_bridge

Parametrised PicoBlaze (KCPSM6) port-mapped I/O bridge for the Nexys4 game designs, succeeding the fixed-width board interface. It exposes buttons, switches, LEDs and an N-digit seven-segment bank through a regular port map. It adds a queued RAM probe sequencer, which verifies up to PROBE_DEPTH grid cells in hardware and reports a single valid flag, plus a one-cycle RAM write strobe. It also provides a masked, edge-latched multi-source interrupt controller.

## Interface
- NUM_DIGITS, 8, seven-segment digits, 1..16
- LED_WIDTH, 16, LED count, 8 or 16
- PROBE_DEPTH, 5, probe queue entries, 1..15
- RAM_AW, 8, game-board RAM address width, ≤8
- RAM_DW, 2, RAM data width, ≤8
- RAM_RD_LAT, 1, RAM read latency in cycles, 1..3
- NUM_IRQ, 4, external interrupt sources, 1..8
- OOB_ADDR, 8'hFF, out-of-bounds sentinel address
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- port_id  in  8  PicoBlaze port address
- out_port  in  8  PicoBlaze write data
- write_strobe  in  1  PicoBlaze write qualifier
- in_port  out  8  registered read data to PicoBlaze
- interrupt  out  1  interrupt to PicoBlaze
- interrupt_ack  in  1  PicoBlaze acknowledge
- irq_src  in  NUM_IRQ  interrupt request lines, rising-edge sensitive
- db_btns  in  5  debounced buttons
- db_sw  in  16  debounced switches
- leds  out  LED_WIDTH  LED drive
- digits  out  5*NUM_DIGITS  digit i at [5i+4:5i]
- dp  out  NUM_DIGITS  decimal points
- ram_addr  out  RAM_AW  RAM address (read or write)
- ram_we  out  1  RAM write enable, single-cycle pulse
- ram_wdata  out  RAM_DW  RAM write data
- ram_rdata  in  RAM_DW  RAM read data

## Operation
- Port map. R = read, W = write (write_strobe-qualified).
  - 0x00 R buttons {3'b0,db_btns}; 0x01 R db_sw[7:0]; 0x02 R db_sw[15:8].
  - 0x03/0x04 RW LED low/high byte; 0x05/0x06 RW dp low/high byte.
  - Ports beyond LED_WIDTH/NUM_DIGITS write-ignore and read 0.
  - 0x07 W probe push.
  - 0x08 W control: bit0 start, bit1 clear. R status {busy,done,full,empty,count[3:0]}.
  - 0x09 R result {5'b0,ovf,oob,valid}; 0x0A R hit count.
  - 0x0B W write address; 0x0C W write data, which triggers the RAM write; 0x0D R sticky write-drop flag (bit0).
  - 0x0E RW irq mask; 0x0F R pending, W1C.
  - 0x20+i RW digit i (5 bits).
  - Unmapped ports read 0x00.
- Probe push: appends out_port to the queue.
  - Ignored when busy.
  - When full: ignored and ovf set.
  - OOB_ADDR is stored but never issued to RAM; it sets oob.
- Start with count>0: enters the sequencer FSM, clears hits/valid/done.
- Start with count=0: done=1, valid=1 immediately.
- Start while busy: ignored.
- Clear: empties the queue and zeroes hits/oob/ovf/done/valid. Clear while busy aborts to IDLE.
- Sequencer FSM:
  - IDLE → ISSUE on start.
  - ISSUE: ram_addr←queue[idx] (OOB entries skip to next).
  - WAIT: RAM_RD_LAT cycles, then sample ram_rdata. Nonzero increments hits (saturating at 255). Then idx++.
  - Back to ISSUE while idx<count, else DONE.
  - DONE: done=1, valid=(hits==0 && !oob). Return to IDLE; the queue is retained, so a rerun is possible.
- Writes:
  - 0x0C write while idle: ram_addr←addr register, ram_wdata←out_port[RAM_DW-1:0], ram_we=1 for exactly one cycle.
  - 0x0C write while busy: dropped, and the 0x0D drop flag is set (cleared by reset or control clear).
- Interrupts:
  - pending[i] sets on a rising edge of irq_src[i].
  - interrupt sets when a masked pending bit newly sets. It clears on interrupt_ack. A new masked event in the ack cycle wins, so interrupt stays 1.
- Reset: all outputs and registers are 0, FSM IDLE, queue empty, in_port 0x00, interrupt 0, ram_we 0.

## Timing
- in_port is registered: data for the port_id at cycle N appears at N+1. There is no read strobe and reads have no side effects.
- Register writes are visible on outputs at N+1.
- ram_we asserts at N+1 for one cycle only.
- Probe latency after start: (RAM_RD_LAT+2)·k+1 cycles for k non-OOB entries. OOB entries cost 1 cycle each. busy=1 from N+1 through the DONE cycle.
- irq_src is sampled once per cycle; edge detection delays pending by 1 cycle. interrupt asserts 1 cycle after pending.

## Test plan
- Push 0x11,0x12,0x13, start; RAM returns 0,0,0 (RAM_RD_LAT=1) → done after 10 cycles, port 0x09 = 0x01, 0x0A = 0x00, ram_addr sequence 0x11,0x12,0x13.
- Push 0x20,0xFF, start → no RAM access to 0xFF, 0x09 = 0x02 (oob, not valid).
- Push 6 entries with PROBE_DEPTH=5 → status full=1, count=5, 0x09 bit2 ovf=1; clear → empty=1, 0x09 = 0x00.
- Write 0x0B←0x42, 0x0C←0x03 → ram_we high exactly one cycle, ram_addr=0x42, ram_wdata=2'b11. Repeat during busy → no ram_we, 0x0D reads 0x01.
- Mask 0x05, pulse irq_src[0] and irq_src[1] → pending 0x03, interrupt=1. interrupt_ack → interrupt=0. irq_src[2] edge coincident with ack → interrupt stays 1. Write 0x0F←0x07 → pending 0.
- Assert reset_n=0 mid-probe (WAIT state) → immediately IDLE, all outputs 0, digits 0, in_port 0x00.
